// File: rtl/seq_pkg.sv
// Shared state encoding for the serializer and sequence-detector blocks.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: parallel load, shift left, MSB out.
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], 1'b0};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/pattern_serializer.sv
// Serializes a captured pattern MSB first, repeat_cnt times back to back.
// Define PATTERN_SERIALIZER_GAP_EN to insert one zero gap bit between repetitions.
module pattern_serializer
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  seq_state_t       r_state;
  logic [PAT_W-1:0] r_pat;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [PAT_W-1:0] w_load_src;
  logic [PAT_W-1:0] w_load_val;

  // The shift register is loaded pre-shifted: its MSB always holds the next bit to emit.
  always_comb begin
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_load_src = r_pat;
    case (r_state)
      ST_IDLE: begin
        w_load     = start;
        w_load_src = pattern;
      end
      ST_SHIFT: begin
        if (r_bit_cnt == LAST_BIT) begin
`ifdef PATTERN_SERIALIZER_GAP_EN
          w_load = 1'b0;
`else
          w_load = (r_rep_cnt > ONE_REP);
`endif
        end else begin
          w_shift = 1'b1;
        end
      end
`ifdef PATTERN_SERIALIZER_GAP_EN
      ST_GAP: begin
        w_load = 1'b1;
      end
`endif
      default: begin
        w_load  = 1'b0;
        w_shift = 1'b0;
      end
    endcase
    w_load_val = {w_load_src[PAT_W-2:0], 1'b0};
  end

  piso_shift_reg #(
    .W(PAT_W)
  ) u_piso (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_din  (w_load_val),
    .o_msb  (w_msb)
  );

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pat       <= '0;
      r_bit_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pat     <= pattern;
            r_rep_cnt <= repeat_cnt;
            r_bit_cnt <= '0;
            if (repeat_cnt != '0) begin
              r_state     <= ST_SHIFT;
              r_ser_out   <= pattern[PAT_W-1];
              r_ser_valid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_DONE;
              r_ser_out   <= 1'b0;
              r_ser_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end else begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_bit_cnt != LAST_BIT) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_ser_out <= w_msb;
          end else if (r_rep_cnt > ONE_REP) begin
            r_rep_cnt <= r_rep_cnt - ONE_REP;
            r_bit_cnt <= '0;
`ifdef PATTERN_SERIALIZER_GAP_EN
            r_state   <= ST_GAP;
            r_ser_out <= 1'b0;
`else
            r_ser_out <= r_pat[PAT_W-1];
`endif
          end else begin
            r_state     <= ST_DONE;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`ifdef PATTERN_SERIALIZER_GAP_EN
        ST_GAP: begin
          r_state   <= ST_SHIFT;
          r_ser_out <= r_pat[PAT_W-1];
        end
`endif
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pattern_serializer.sv
// Randomized self-checking bench for pattern_serializer against a per-cycle stream model.
// Honors PATTERN_SERIALIZER_GAP_EN the same way the design does.
module tb_pattern_serializer;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic valid;
    logic dout;
    logic busy;
    logic done;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  pattern_serializer #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .repeat_cnt(repeat_cnt),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t e);
    check({tag, ".valid"}, 32'(ser_valid), 32'(e.valid));
    check({tag, ".out"},   32'(ser_out),   32'(e.dout));
    check({tag, ".busy"},  32'(busy),      32'(e.busy));
    check({tag, ".done"},  32'(done),      32'(e.done));
  endtask

  // Expected stream per cycle after the accepting edge: bits, optional gaps, done, idle.
  function automatic void build_expected(input logic [PAT_W-1:0] pat, input int n);
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        exp_q.push_back('{1'b1, pat[b], 1'b1, 1'b0});
      end
`ifdef PATTERN_SERIALIZER_GAP_EN
      if (r < n - 1) exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
`endif
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
  endfunction

  task automatic run_txn(input logic [PAT_W-1:0] pat, input int n, input bit disturb, input string name);
    build_expected(pat, n);
    @(negedge clk);
    start      = 1'b1;
    pattern    = pat;
    repeat_cnt = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_obs($sformatf("%s[%0d]", name, i), exp_q[i]);
      if (disturb && (i < exp_q.size() - 1)) begin
        pattern    = PAT_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
        start      = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      if (i < exp_q.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_reset_mid(input logic [PAT_W-1:0] pat, input int n, input string name);
    build_expected(pat, n);
    @(negedge clk);
    start      = 1'b1;
    pattern    = pat;
    repeat_cnt = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_obs({name, ".b0"}, exp_q[0]);
    @(posedge clk);
    #1;
    check_obs({name, ".b1"}, exp_q[1]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_obs({name, ".rst"}, '{1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_obs($sformatf("%s.post%0d", name, i), '{1'b0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset", '{1'b0, 1'b0, 1'b0, 1'b0});
    // Reset wins over a simultaneous start.
    start      = 1'b1;
    pattern    = 4'b1011;
    repeat_cnt = 4'd3;
    @(posedge clk);
    #1;
    check_obs("rst_vs_start", '{1'b0, 1'b0, 1'b0, 1'b0});
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_obs("idle", '{1'b0, 1'b0, 1'b0, 1'b0});

    run_txn(4'b1011, 1, 1'b0, "one");
    run_txn(4'b1011, 2, 1'b0, "two");
    run_txn(4'b1011, 0, 1'b0, "zero");
    run_txn(4'b1011, 2, 1'b1, "disturb");
    run_txn(4'b1001, 15, 1'b0, "maxrep");
    run_reset_mid(4'b1011, 2, "rstmid");
    run_txn(4'b1011, 1, 1'b0, "after_rst");

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_reset_mid(PAT_W'($urandom), $urandom_range(1, 15), $sformatf("rrst%0d", t));
      end else begin
        run_txn(PAT_W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", t));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
